// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FP multiplier issue scheduler.
// FPUMULS_SCHED_RAISE_EN adds exception bits to the result FIFO entry.
package fpu_sched_pkg;

  localparam int unsigned RES_W     = 33;
  localparam int unsigned RAISE_W   = 11;
  localparam int unsigned RM_W      = 3;
  localparam int unsigned PORT_W    = 2;   // covers up to four requesters
  localparam int unsigned TAG_MAX_W = 16;

  localparam logic [RM_W-1:0] RM_TRUNC     = 3'd0;
  localparam logic [RM_W-1:0] RM_NEAR_EVEN = 3'd1;
  localparam logic [RM_W-1:0] RM_NEAR_MAX  = 3'd2;
  localparam logic [RM_W-1:0] RM_NEAR_MIN  = 3'd3;
  localparam logic [RM_W-1:0] RM_AWAY      = 3'd4;
  localparam logic [RM_W-1:0] RM_UP        = 3'd5;
  localparam logic [RM_W-1:0] RM_DOWN      = 3'd6;

  typedef struct packed {
    logic                 vld;
    logic [PORT_W-1:0]    port;
    logic [TAG_MAX_W-1:0] tag;
  } shadow_t;

  typedef struct packed {
    logic [RES_W-1:0]     res;
    logic [PORT_W-1:0]    port;
    logic [TAG_MAX_W-1:0] tag;
`ifdef FPUMULS_SCHED_RAISE_EN
    logic [RAISE_W-1:0]   raise;
`endif
  } fifo_ent_t;

endpackage

// File: rtl/fpumuls_sched_fifo.sv
// DEPTH-entry result FIFO with occupancy count; head is zero while empty.
module fpumuls_sched_fifo
  import fpu_sched_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  fifo_ent_t     push_data_i,
  input  logic          pop_i,
  output fifo_ent_t     head_o,
  output logic          vld_o,
  output logic [CW-1:0] count_o
);

  fifo_ent_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign vld_o   = (cnt_q != '0);
  assign count_o = cnt_q;
  assign head_o  = vld_o ? mem_q[rd_q] : '0;
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & vld_o & ~flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  // Credits make this unreachable; a hit means the credit accounting broke.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && cnt_q == CW'(DEPTH)));

endmodule

// File: rtl/fpumuls_sched.sv
// Round-robin issue scheduler and credit-protected result buffer for fpumuls.
// FPUMULS_SCHED_RAISE_EN adds rsp_raise_o, sticky raise_acc_o and raise_clr_i.
module fpumuls_sched
  import fpu_sched_pkg::*;
#(
  parameter  int unsigned NREQ  = 2,
  parameter  int unsigned LAT   = 4,
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned TAGW  = 6,
  localparam int unsigned PW    = $clog2(NREQ),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_vld_i,
  output logic [NREQ-1:0]            req_rdy_o,
  input  logic [NREQ-1:0][RES_W-1:0] req_a_i,
  input  logic [NREQ-1:0][RES_W-1:0] req_b_i,
  input  logic [NREQ-1:0]            req_copya_i,
  input  logic [NREQ-1:0][RM_W-1:0]  req_rmode_i,
  input  logic [NREQ-1:0][TAGW-1:0]  req_tag_i,
  output logic [RES_W-1:0]           mul_a_o,
  output logic [RES_W-1:0]           mul_b_o,
  output logic                       mul_copya_o,
  output logic                       mul_en_o,
  output logic [RM_W-1:0]            mul_rmode_o,
  input  logic [RES_W-1:0]           mul_res_i,
  input  logic [RAISE_W-1:0]         mul_raise_i,
  output logic                       rsp_vld_o,
  input  logic                       rsp_rdy_i,
  output logic [RES_W-1:0]           rsp_res_o,
  output logic [PW-1:0]              rsp_port_o,
  output logic [TAGW-1:0]            rsp_tag_o,
`ifdef FPUMULS_SCHED_RAISE_EN
  output logic [RAISE_W-1:0]         rsp_raise_o,
  output logic [RAISE_W-1:0]         raise_acc_o,
  input  logic                       raise_clr_i,
`endif
  input  logic                       flush_i,
  output logic                       busy_o
);

  logic [PW-1:0]    last_q, last_d, win, idx;
  logic             found, grant, push, pop;
  logic [CW-1:0]    inflight_q, inflight_d, fifo_cnt;
  logic [RES_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic             mul_copya_q, mul_copya_d, mul_en_q, mul_en_d;
  logic [RM_W-1:0]  mul_rmode_q, mul_rmode_d;
  logic [PW-1:0]    iss_port_q, iss_port_d;
  logic [TAGW-1:0]  iss_tag_q, iss_tag_d;
  shadow_t          shadow_q [LAT];
  shadow_t          shadow_d [LAT];
  fifo_ent_t        push_ent, head;
  logic             unused_head;

  // Round-robin search starting one past the last winner; credits gate the grant.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = PW'((32'(last_q) + k) % NREQ);
      if (!found && req_vld_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    grant = found & ~rst & ~flush_i & ((32'(inflight_q) + 32'(fifo_cnt)) < DEPTH);
    req_rdy_o = '0;
    if (grant) req_rdy_o[win] = 1'b1;
  end

  assign push = shadow_q[LAT-1].vld;
  assign pop  = rsp_vld_o & rsp_rdy_i;

  always_comb begin
    last_d      = last_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_copya_d = mul_copya_q;
    mul_rmode_d = mul_rmode_q;
    iss_port_d  = iss_port_q;
    iss_tag_d   = iss_tag_q;
    mul_en_d    = grant;
    inflight_d  = inflight_q;
    if (grant) begin
      last_d      = win;
      mul_a_d     = req_a_i[win];
      mul_b_d     = req_b_i[win];
      mul_copya_d = req_copya_i[win];
      mul_rmode_d = req_rmode_i[win];
      iss_port_d  = win;
      iss_tag_d   = req_tag_i[win];
    end
    if (flush_i)              inflight_d = '0;
    else if (grant && !push)  inflight_d = inflight_q + CW'(1);
    else if (!grant && push)  inflight_d = inflight_q - CW'(1);
  end

  // Shadow stage 0 tracks the op the multiplier samples on this edge.
  always_comb begin
    shadow_d[0].vld  = mul_en_q & ~flush_i;
    shadow_d[0].port = PORT_W'(iss_port_q);
    shadow_d[0].tag  = TAG_MAX_W'(iss_tag_q);
    for (int unsigned i = 1; i < LAT; i++) begin
      shadow_d[i]     = shadow_q[i-1];
      shadow_d[i].vld = shadow_q[i-1].vld & ~flush_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= PW'(NREQ - 1);
      inflight_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_copya_q <= 1'b0;
      mul_en_q    <= 1'b0;
      mul_rmode_q <= '0;
      iss_port_q  <= '0;
      iss_tag_q   <= '0;
      for (int unsigned i = 0; i < LAT; i++) shadow_q[i] <= '0;
    end else begin
      last_q      <= last_d;
      inflight_q  <= inflight_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_copya_q <= mul_copya_d;
      mul_en_q    <= mul_en_d;
      mul_rmode_q <= mul_rmode_d;
      iss_port_q  <= iss_port_d;
      iss_tag_q   <= iss_tag_d;
      for (int unsigned i = 0; i < LAT; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  always_comb begin
    push_ent       = '0;
    push_ent.res   = mul_res_i;
    push_ent.port  = shadow_q[LAT-1].port;
    push_ent.tag   = shadow_q[LAT-1].tag;
`ifdef FPUMULS_SCHED_RAISE_EN
    push_ent.raise = mul_raise_i;
`endif
  end

  fpumuls_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .push_i      (push),
    .push_data_i (push_ent),
    .pop_i       (pop),
    .head_o      (head),
    .vld_o       (rsp_vld_o),
    .count_o     (fifo_cnt)
  );

  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_copya_o = mul_copya_q;
  assign mul_en_o    = mul_en_q;
  assign mul_rmode_o = mul_rmode_q;
  assign rsp_res_o   = head.res;
  assign rsp_port_o  = PW'(head.port);
  assign rsp_tag_o   = TAGW'(head.tag);
  assign busy_o      = (inflight_q != '0) || (fifo_cnt != '0);
  assign unused_head = ^{head.port, head.tag};

`ifdef FPUMULS_SCHED_RAISE_EN
  logic [RAISE_W-1:0] raise_acc_q, raise_acc_d;

  // Popped bits are ORed in after the clear so they survive a same-cycle clear.
  always_comb begin
    raise_acc_d = raise_clr_i ? '0 : raise_acc_q;
    if (pop) raise_acc_d = raise_acc_d | head.raise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) raise_acc_q <= '0;
    else     raise_acc_q <= raise_acc_d;
  end

  assign rsp_raise_o = head.raise;
  assign raise_acc_o = raise_acc_q;
`else
  logic unused_raise;
  assign unused_raise = ^mul_raise_i;
`endif

endmodule

// File: tb/tb_fpumuls_sched.sv
// Directed self-checking bench for fpumuls_sched with a stub 4-stage multiplier
// (result = copyA ? A : A+B, raise = A[10:0]). Honors FPUMULS_SCHED_RAISE_EN.
module tb_fpumuls_sched;
  import fpu_sched_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 6;
  localparam logic [32:0] ONE   = 33'h0_3F80_0000;

  logic                       clk, rst;
  logic [NREQ-1:0]            req_vld, req_rdy, req_copya;
  logic [NREQ-1:0][32:0]      req_a, req_b;
  logic [NREQ-1:0][2:0]       req_rmode;
  logic [NREQ-1:0][TAGW-1:0]  req_tag;
  logic [32:0]                mul_a, mul_b, mul_res, rsp_res;
  logic                       mul_copya, mul_en;
  logic [2:0]                 mul_rmode;
  logic [10:0]                mul_raise;
  logic                       rsp_vld, rsp_rdy, flush, busy;
  logic [0:0]                 rsp_port;
  logic [TAGW-1:0]            rsp_tag;
`ifdef FPUMULS_SCHED_RAISE_EN
  logic [10:0]                rsp_raise, raise_acc;
  logic                       raise_clr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fpumuls_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy),
    .req_a_i(req_a), .req_b_i(req_b), .req_copya_i(req_copya),
    .req_rmode_i(req_rmode), .req_tag_i(req_tag),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_copya_o(mul_copya),
    .mul_en_o(mul_en), .mul_rmode_o(mul_rmode),
    .mul_res_i(mul_res), .mul_raise_i(mul_raise),
    .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_res_o(rsp_res),
    .rsp_port_o(rsp_port), .rsp_tag_o(rsp_tag),
`ifdef FPUMULS_SCHED_RAISE_EN
    .rsp_raise_o(rsp_raise), .raise_acc_o(raise_acc), .raise_clr_i(raise_clr),
`endif
    .flush_i(flush), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub multiplier: sampled on the issue edge, result visible LAT cycles later.
  logic [32:0] mp_res   [LAT];
  logic [10:0] mp_raise [LAT];
  always @(posedge clk) begin
    mp_res[0]   <= mul_copya ? mul_a : mul_a + mul_b;
    mp_raise[0] <= mul_a[10:0];
    for (int i = 1; i < LAT; i++) begin
      mp_res[i]   <= mp_res[i-1];
      mp_raise[i] <= mp_raise[i-1];
    end
  end
  assign mul_res   = mp_res[LAT-1];
  assign mul_raise = mp_raise[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tg, got, exp);
    end
  endtask

  // Waits (bounded) for a head, checks it, then advances one cycle.
  task automatic expect_rsp(input string tg, input logic [32:0] res,
                            input logic [0:0] port, input logic [TAGW-1:0] tag);
    int n = 0;
    while (!rsp_vld && n < 20) begin
      tick();
      n++;
    end
    check({tg, "_vld"}, rsp_vld, 1);
    check({tg, "_res"}, rsp_res, res);
    check({tg, "_port"}, rsp_port, port);
    check({tg, "_tag"}, rsp_tag, tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int stale;
    rst = 1'b1; flush = 1'b0; rsp_rdy = 1'b0;
    req_vld = 2'b01; req_copya = '0; req_rmode = '0; req_tag = '0;
    req_a = '0; req_b = '0;
`ifdef FPUMULS_SCHED_RAISE_EN
    raise_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_rdy", req_rdy, 0);
    check("rst_mul_en", mul_en, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_busy", busy, 0);
    req_vld = 2'b00;
    rst = 1'b0;
    tick();

    // Single op: grant cycle 0, mul_en cycle 1, response cycle LAT+2.
    req_a[0] = ONE; req_b[0] = ONE; req_tag[0] = 6'd5; req_rmode[0] = RM_UP;
    req_vld = 2'b01;
    #1;
    check("t1_grant", req_rdy, 2'b01);
    tick();
    req_vld = 2'b00;
    check("t1_mul_en", mul_en, 1);
    check("t1_mul_a", mul_a, ONE);
    check("t1_mul_rmode", mul_rmode, 5);
    check("t1_mul_copya", mul_copya, 0);
    repeat (4) tick();
    check("t1_rsp_early", rsp_vld, 0);
    tick();
    check("t1_rsp_vld", rsp_vld, 1);
    check("t1_rsp_tag", rsp_tag, 5);
    check("t1_rsp_port", rsp_port, 0);
    check("t1_rsp_res", rsp_res, 33'h0_7F00_0000);
    check("t1_busy", busy, 1);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    check("t1_popped", rsp_vld, 0);
    check("t1_idle", busy, 0);

    // Both ports valid: last winner was port 0, so grants go 1,0,1,0.
    req_a[0] = 33'h100;         req_b[0] = 33'h23; req_tag[0] = 6'd10;
    req_copya[0] = 1'b0;        req_rmode[0] = RM_TRUNC;
    req_a[1] = 33'h1_0000_0055; req_b[1] = 33'h7;  req_tag[1] = 6'd20;
    req_copya[1] = 1'b1;        req_rmode[1] = RM_DOWN;
    req_vld = 2'b11; rsp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_grant", req_rdy, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      check("t2_mul_copya", mul_copya, (k % 2 == 0) ? 1 : 0);
    end
    req_vld = 2'b00;
    expect_rsp("t2_r0", 33'h1_0000_0055, 1'b1, 6'd20);
    expect_rsp("t2_r1", 33'h123, 1'b0, 6'd10);
    expect_rsp("t2_r2", 33'h1_0000_0055, 1'b1, 6'd20);
    expect_rsp("t2_r3", 33'h123, 1'b0, 6'd10);
    rsp_rdy = 1'b0;

    // Credit exhaustion with the consumer stalled, then one pop frees one slot.
    req_vld = 2'b01; acc = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_rdy == 2'b01) acc++;
      tick();
    end
    check("t3_accepts", acc, DEPTH);
    #1;
    check("t3_rdy_blocked", req_rdy, 0);
    check("t3_busy", busy, 1);
    rsp_rdy = 1'b1;
    #1;
    check("t3_rdy_pop_cycle", req_rdy, 0);
    tick();
    rsp_rdy = 1'b0;
    #1;
    check("t3_rdy_after_pop", req_rdy, 2'b01);
    tick();
    #1;
    check("t3_rdy_again", req_rdy, 0);
    req_vld = 2'b00; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_flush_busy", busy, 0);

    // Flush with one op buffered and three in flight.
    req_tag[0] = 6'd1; req_vld = 2'b01;
    #1;
    check("t4_g0", req_rdy, 2'b01);
    tick();
    req_vld = 2'b00;
    tick();
    tick();
    req_tag[0] = 6'd2; req_vld = 2'b01;
    tick();
    req_tag[0] = 6'd3;
    tick();
    req_tag[0] = 6'd4;
    tick();
    req_vld = 2'b00;
    check("t4_pre_rsp_vld", rsp_vld, 1);
    check("t4_pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_rsp_vld", rsp_vld, 0);
    check("t4_busy", busy, 0);
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_vld || busy) stale++;
    end
    check("t4_stale", stale, 0);
    req_vld = 2'b01; acc = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_rdy == 2'b01) acc++;
      tick();
    end
    check("t4_credits", acc, DEPTH);
    req_vld = 2'b00; flush = 1'b1;
    tick();
    flush = 1'b0;

    // Reset with two ops in flight; port 0 wins first afterwards.
    rsp_rdy = 1'b1; req_tag[0] = 6'd10; req_vld = 2'b11;
    #1;
    check("t5_g0", req_rdy, 2'b10);
    tick();
    #1;
    check("t5_g1", req_rdy, 2'b01);
    tick();
    req_vld = 2'b00;
    #1;
    check("t5_mul_en_pre", mul_en, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t5_mul_en", mul_en, 0);
    check("t5_busy", busy, 0);
    check("t5_rsp_vld", rsp_vld, 0);
    check("t5_mul_a", mul_a, 0);
    check("t5_mul_copya", mul_copya, 0);
    req_vld = 2'b11;
    #1;
    check("t5_rdy_in_rst", req_rdy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t5_first_grant", req_rdy, 2'b01);
    tick();
    req_vld = 2'b00;
    expect_rsp("t5_post", 33'h123, 1'b0, 6'd10);
    check("t5_idle", busy, 0);

`ifdef FPUMULS_SCHED_RAISE_EN
    // Pop coinciding with a clear keeps the popped exception bits.
    rsp_rdy = 1'b0; req_a[0] = 33'h108; req_b[0] = 33'h0; req_vld = 2'b01;
    tick();
    req_vld = 2'b00;
    expect_rsp("t6", 33'h108, 1'b0, 6'd10);
    check("t6_rsp_raise", rsp_raise, 11'h108);
    rsp_rdy = 1'b1; raise_clr = 1'b1;
    tick();
    rsp_rdy = 1'b0; raise_clr = 1'b0;
    check("t6_acc_survives", raise_acc, 11'h108);
    raise_clr = 1'b1;
    tick();
    raise_clr = 1'b0;
    check("t6_acc_cleared", raise_acc, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpumuls_sched.md
# fpumuls_sched

Issue scheduler and result buffer for the shared single-precision FP multiplier (`fpumuls`, 4-stage). Arbitrates up to NREQ requester ports round-robin onto the single multiplier issue slot, tracks in-flight operations in a shadow pipeline, and buffers results in a credit-protected FIFO. The FIFO is needed because the multiplier pipeline cannot stall. Sits between the FP issue ports and the multiplier; drives its `A/B/copyA/en/rmode` and consumes `res/raise`.

## Interface
- NREQ, 2: number of requester ports (2..4)
- LAT, 4: multiplier latency, issue edge to `mul_res` valid edge
- DEPTH, 4: result FIFO entries (power of two, ≥ LAT)
- TAGW, 6: requester tag width
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- req_vld  in  NREQ  request valid per port
- req_rdy  out  NREQ  grant; request accepted when vld&rdy
- req_A, req_B  in  NREQ×33  operands (internal 33-bit format)
- req_copyA  in  NREQ  pass A through
- req_rmode  in  NREQ×3  rounding mode
- req_tag  in  NREQ×TAGW  tag returned with result
- mul_A, mul_B  out  33  to multiplier
- mul_copyA  out  1
- mul_en  out  1  issue strobe
- mul_rmode  out  3
- mul_res  in  33  multiplier result
- mul_raise  in  11  multiplier exception bits
- rsp_vld  out  1  FIFO head valid
- rsp_rdy  in  1  consumer accepts head
- rsp_res  out  33
- rsp_port  out  $clog2(NREQ)  originating port
- rsp_tag  out  TAGW
- flush  in  1  discard in-flight and buffered ops
- busy  out  1  any op in flight or buffered

## Operation
- Credits: `credit = DEPTH − inflight − occupancy`. Issue permitted only when credit > 0 and `flush`=0.
- Arbiter: round-robin; search starts at `last+1` mod NREQ. `req_rdy` is one-hot, asserted only for the winner with `req_vld`=1; `last` updates on grant.
- On grant: `mul_*` registered from the winner's fields, `mul_en`=1 for one cycle; shadow stage 0 gets {valid, port, tag}.
- Shadow pipeline: LAT stages of {valid, port, tag}, shifted every cycle. When stage LAT−1 is valid, {mul_res, port, tag, raise} is pushed into the FIFO.
- FIFO: head drives `rsp_*`; pop on `rsp_vld & rsp_rdy`. Push and pop in the same cycle keep occupancy unchanged. Wrap-around uses modulo-DEPTH pointers. Overflow is impossible by credit construction; a push into a full FIFO is an assertion failure.
- `inflight` increments on grant and decrements on shadow exit. Simultaneous grant and exit leave it unchanged.
- flush: clears all shadow valids, FIFO pointers/occupancy and `inflight` in the same edge. No grant in the flush cycle; `rsp_vld`=0 from the next cycle. `last` is retained.
- `busy` = inflight≠0 | occupancy≠0.

## Timing
- Reset values: `req_rdy`=0, `mul_en`=0, `mul_A/B`=0, `mul_copyA`=0, `mul_rmode`=0, `rsp_vld`=0, `rsp_*`=0, `busy`=0, `last`=NREQ−1 (port 0 wins first), credit=DEPTH.
- Grant to `mul_en`: 1 cycle. `mul_en` to FIFO push: LAT cycles. Push to `rsp_vld`: 1 cycle. Total request-accept to `rsp_vld` is LAT+2.
- Throughput: one issue per cycle while credits remain. With `rsp_rdy` held 0, exactly DEPTH ops are accepted, then `req_rdy`=0.
- A pop frees a credit usable for a grant in the next cycle, not the same one.
- Reset mid-operation: everything is cleared asynchronously and in-flight results are dropped. `mul_en` deasserts immediately.

## Configuration
- `FPUMULS_SCHED_RAISE_EN` defined: FIFO stores `mul_raise`; adds outputs `rsp_raise` (11) and a sticky `raise_acc` (11). `raise_acc` ORs in `rsp_raise` on each pop and is cleared by input `raise_clr`. On a simultaneous clear and pop, the popped bits survive. `raise_acc` resets to 0.
- Undefined: no raise storage or ports; `mul_raise` is ignored.

## Structure
- Shared package `fpu_sched_pkg`: shadow entry typedef {vld, port, tag}, FIFO entry typedef, rounding-mode constants (TRUNC=0 … DOWN=6).
- One sub-module `fpumuls_sched_fifo` (DEPTH-entry synchronous FIFO with count output). Arbiter and shadow pipeline stay in the top.

## Test plan
- Single op, port 0, A=B=1.0, tag 5 → `mul_en` at cycle 1, `rsp_vld` at cycle LAT+2 with tag 5 and port 0.
- Ports 0 and 1 both continuously valid → grants alternate 0,1,0,1; responses return in grant order.
- `rsp_rdy`=0, port 0 streaming → exactly 4 accepts, then `req_rdy`=0. One pop → exactly one more accept on the following cycle.
- Flush with 3 in flight and 1 buffered → `rsp_vld`=0 next cycle, `busy`=0, credit=4. No stale response appears within 10 cycles.
- `rst` pulsed with 2 ops in flight → all outputs at reset values immediately. The first post-reset grant goes to port 0.
- With `FPUMULS_SCHED_RAISE_EN`: op with raise bit 3 set, popped while `raise_clr`=1 → `raise_acc` bit 3 = 1.
